// File: rtl/grid_pkg.sv
// Shared types for the grid scanner: grid geometry, row index type, FSM states
// and the cursor bit-mask helper used by the overlay.
package grid_pkg;

  localparam int GRID_N = 16;

  typedef logic [GRID_N-1:0][GRID_N-1:0] grid_t;
  typedef logic [3:0]                    idx_t;

  typedef enum logic [1:0] {
    SNAP  = 2'd0,
    SEND  = 2'd1,
    DWELL = 2'd2
  } scan_state_t;

  // One-hot mask selecting the cursor column within a row
  function automatic logic [GRID_N-1:0] cursor_mask(input idx_t col);
    cursor_mask      = {GRID_N{1'b0}};
    cursor_mask[col] = 1'b1;
  endfunction

endpackage

// File: rtl/grid_scanner_if.sv
// Row stream between the scanner and the LED driver: valid/ready handshake
// carrying one 16-cell row and its index.
interface grid_scanner_if;
  import grid_pkg::*;

  logic              row_valid;
  logic              row_ready;
  logic [GRID_N-1:0] row_data;
  idx_t              row_index;

  modport master (output row_valid, output row_data, output row_index, input row_ready);
  modport slave  (input row_valid, input row_data, input row_index, output row_ready);

endinterface

// File: rtl/grid_scanner_blink_gen.sv
// Cursor blink timebase: counts frames and flips blink_phase_o every
// BLINK_FRAMES frames, advancing only on en_i pulses.
module blink_gen #(
  parameter int BLINK_FRAMES = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic en_i,
  output logic blink_phase_o
);

  localparam int FCW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FCW-1:0] FRAME_LAST = FCW'(BLINK_FRAMES - 1);

  logic [FCW-1:0] frame_cnt_q, frame_cnt_d;
  logic           phase_q, phase_d;

  // Counter advance and phase toggle on each enabled frame boundary
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    phase_d     = phase_q;
    if (en_i) begin
      if (frame_cnt_q == FRAME_LAST) begin
        frame_cnt_d = {FCW{1'b0}};
        phase_d     = ~phase_q;
      end else begin
        frame_cnt_d = frame_cnt_q + FCW'(1);
        phase_d     = phase_q;
      end
    end else begin
      frame_cnt_d = frame_cnt_q;
      phase_d     = phase_q;
    end
  end

  // Frame counter and phase registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      frame_cnt_q <= {FCW{1'b0}};
      phase_q     <= 1'b0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      phase_q     <= phase_d;
    end
  end

  assign blink_phase_o = phase_q;

endmodule

// File: rtl/grid_scanner.sv
// Frame scanner: snapshots the live grid once per frame and streams it row by
// row over a valid/ready link, holding each accepted row for DWELL cycles.
module grid_scanner #(
  parameter int DWELL        = 1000,
  parameter int BLINK_FRAMES = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  grid_pkg::grid_t grid,
  input  grid_pkg::idx_t  cursor_row,
  input  grid_pkg::idx_t  cursor_col,
  input  logic            blink_en,
  output logic            frame_start,
  grid_scanner_if.master  row_if
);
  import grid_pkg::*;

  localparam int DCW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [DCW-1:0] DWELL_LOAD = DCW'(DWELL - 1);

  scan_state_t       state_q, state_d;
  idx_t              row_index_q, row_index_d;
  logic              row_valid_q, row_valid_d;
  logic              frame_start_q, frame_start_d;
  logic [DCW-1:0]    dwell_cnt_q, dwell_cnt_d;
  grid_t             snapshot_q, snapshot_d;
  logic              first_q, first_d;
  logic              blink_phase_s;
  logic              blink_en_s;
  logic              overlay_s;
  logic [GRID_N-1:0] row_data_s;

  // The post-reset frame_start is frame 0 itself, so it does not advance the blink timebase
  assign blink_en_s = frame_start_q & ~first_q;

  blink_gen #(
    .BLINK_FRAMES (BLINK_FRAMES)
  ) u_blink (
    .clk           (clk),
    .reset         (reset),
    .en_i          (blink_en_s),
    .blink_phase_o (blink_phase_s)
  );

  // Scan FSM next state; SNAP lingers one extra cycle after reset so frame_start can pulse
  always_comb begin
    state_d       = state_q;
    row_index_d   = row_index_q;
    dwell_cnt_d   = dwell_cnt_q;
    snapshot_d    = snapshot_q;
    frame_start_d = 1'b0;
    case (state_q)
      SNAP: begin
        snapshot_d    = grid;
        row_index_d   = 4'd0;
        frame_start_d = ~frame_start_q;
        if (frame_start_q) begin
          state_d = SEND;
        end else begin
          state_d = SNAP;
        end
      end
      SEND: begin
        if (row_valid_q && row_if.row_ready) begin
          dwell_cnt_d = DWELL_LOAD;
          state_d     = grid_pkg::DWELL;
        end else begin
          state_d = SEND;
        end
      end
      grid_pkg::DWELL: begin
        if (dwell_cnt_q == {DCW{1'b0}}) begin
          if (row_index_q == 4'd15) begin
            state_d       = SNAP;
            row_index_d   = 4'd0;
            frame_start_d = 1'b1;
          end else begin
            state_d     = SEND;
            row_index_d = row_index_q + 4'd1;
          end
        end else begin
          dwell_cnt_d = dwell_cnt_q - DCW'(1);
        end
      end
      default: begin
        state_d = SNAP;
      end
    endcase
    row_valid_d = (state_d == SEND);
    if (frame_start_q) begin
      first_d = 1'b0;
    end else begin
      first_d = first_q;
    end
  end

  // Cursor overlay on the presented row; cursor inputs are used live
  always_comb begin
    overlay_s = blink_en && blink_phase_s && (row_index_q == cursor_row);
    if (overlay_s) begin
      row_data_s = snapshot_q[row_index_q] ^ cursor_mask(cursor_col);
    end else begin
      row_data_s = snapshot_q[row_index_q];
    end
  end

  // All scanner state registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= SNAP;
      row_index_q   <= 4'd0;
      row_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
      dwell_cnt_q   <= {DCW{1'b0}};
      snapshot_q    <= {(GRID_N*GRID_N){1'b0}};
      first_q       <= 1'b1;
    end else begin
      state_q       <= state_d;
      row_index_q   <= row_index_d;
      row_valid_q   <= row_valid_d;
      frame_start_q <= frame_start_d;
      dwell_cnt_q   <= dwell_cnt_d;
      snapshot_q    <= snapshot_d;
      first_q       <= first_d;
    end
  end

  assign frame_start      = frame_start_q;
  assign row_if.row_valid = row_valid_q;
  assign row_if.row_index = row_index_q;
  assign row_if.row_data  = row_data_s;

endmodule

// File: doc/grid_scanner.md
GRID_SCANNER -- requirements
Module: grid_scanner

Interface
REQ-001 SHALL have parameter DWELL, default 1000, meaning clock cycles a row stays displayed after acceptance (minimum 1).
REQ-002 SHALL have parameter BLINK_FRAMES, default 8, meaning frames per cursor blink half-period (minimum 1).
REQ-003 SHALL have port clk  input  1  meaning single clock; all logic on posedge.
REQ-004 SHALL have port reset  input  1  meaning synchronous, active-low reset.
REQ-005 SHALL have port grid  input  [15:0][15:0]  meaning live cell array, indexed grid[row][col].
REQ-006 SHALL have port cursor_row  input  4  meaning cursor row index.
REQ-007 SHALL have port cursor_col  input  4  meaning cursor column index.
REQ-008 SHALL have port blink_en  input  1  meaning enable cursor blink overlay.
REQ-009 SHALL have port row_ready  input  1  meaning downstream LED driver accepts the row.
REQ-010 SHALL have port row_valid  output  1  meaning row_data and row_index are valid.
REQ-011 SHALL have port row_data  output  16  meaning bit c = displayed cell (row_index, c).
REQ-012 SHALL have port row_index  output  4  meaning row being presented.
REQ-013 SHALL have port frame_start  output  1  meaning one-cycle pulse when a new frame snapshot is taken.

Function
REQ-014 FSM states SHALL be SNAP, SEND, DWELL; SNAP follows reset.
REQ-015 SNAP: SHALL latch all of grid into an internal snapshot, pulse frame_start, set row_index=0, and go to SEND next cycle.
REQ-016 SEND: SHALL assert row_valid; on row_valid && row_ready, SHALL load the dwell counter with DWELL-1 and go to DWELL.
REQ-017 While row_valid is high and row_ready is low, row_data and row_index SHALL hold stable.
REQ-018 DWELL: SHALL deassert row_valid and decrement the counter. At 0 it SHALL go to SEND with row_index+1, or to SNAP if row_index=15 (wrap).
REQ-019 row_data SHALL be computed from the snapshot, never the live grid. Edits to grid mid-frame SHALL appear only at the next SNAP.
REQ-020 Overlay: if blink_en=1 and blink_phase=1 and row_index=cursor_row, bit cursor_col of row_data SHALL be inverted. Cursor inputs SHALL be sampled live.
REQ-021 A frame counter SHALL increment on each SNAP. When it reaches BLINK_FRAMES-1 it SHALL clear to 0 and toggle blink_phase.
REQ-022 If blink_en=0, row_data SHALL equal the snapshot row exactly. The frame counter and blink_phase SHALL keep running.
REQ-023 Row period SHALL be DWELL+1+(cycles row_ready is low in SEND); frame period SHALL be 16 row periods + 1 SNAP cycle.
REQ-024 Counter widths SHALL be $clog2 of the parameter, at least 1 bit; there SHALL be no overflow at DWELL=1.

Reset
REQ-025 When reset=0 at posedge: state=SNAP, row_index=0, row_valid=0, row_data=0, frame_start=0, dwell counter=0, frame counter=0, blink_phase=0, snapshot=0.
REQ-026 Reset in any state, including mid-handshake, SHALL abort the row with no partial-transfer memory; the first frame after release SHALL start at row 0.

Structure
REQ-027 Shared package grid_pkg SHALL hold GRID_N=16, typedef grid_t ([15:0][15:0] logic), typedef idx_t (logic [3:0]), and the state enum scan_state_t.
REQ-028 Sub-module blink_gen SHALL be used: frame counter plus blink_phase, enabled by the frame_start pulse.
REQ-029 All registers SHALL be in one always_ff; next-state logic and overlay logic SHALL be in always_comb.

Verification
REQ-030 Reset release with grid[0]=16'h00F0, row_ready=1, DWELL=4, blink_en=0 -> frame_start on cycle 1; row_valid on cycle 2 with row_data=16'h00F0 and row_index=0; row_index=1 presented 5 cycles later.
REQ-031 Hold row_ready=0 for 10 cycles during row 3 -> row_valid stays 1 and row_data/row_index are stable; DWELL starts the cycle after row_ready rises.
REQ-032 Set grid[5][2] from 0 to 1 while row 2 is displayed -> row 5 in this frame shows bit2=0; the next frame shows bit2=1.
REQ-033 With BLINK_FRAMES=2, blink_en=1, cursor (7,9), empty grid -> row 7 data is 16'h0000 in frames 0-1, 16'h0200 in frames 2-3, and 16'h0000 in frames 4-5.
REQ-034 Reset asserted during DWELL of row 15 -> outputs take their reset values next cycle; after release, SNAP occurs and row_index restarts at 0.
REQ-035 DWELL=1, row_ready=1 constantly -> row period is 2 cycles; frame_start pulses every 33 cycles; row_index wraps 15 -> SNAP -> 0.
